control_unit: RTL

Multi-cycle instruction sequencer for the 16-bit RISC core. It fetches 16-bit instructions over a req/ack memory port, decodes them, and drives every control input of the datapath: register-bank read/write strobes and addresses, ALU op, write-back mux select and immediate. It also supplies the latched memory word to the datapath's memory-data input, and consumes the datapath's A-port data and zero flag for stores and conditional jumps.

---
 rtl/control_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 16-bit RISC core.
// Drives the register-bank strobes, ALU op, write-back select and the memory port.
module control_unit #(
    parameter int unsigned          PC_W     = 8,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,

    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,

    output logic [15:0]     cu_mem_data,
    output logic [7:0]      cu_imm,
    output logic [1:0]      cu_sel,
    output logic [3:0]      cu_write_addr,
    output logic            cu_write,
    output logic [3:0]      cu_a_addr,
    output logic            cu_a_read,
    output logic [3:0]      cu_b_addr,
    output logic            cu_b_read,
    output logic [3:0]      cu_alu_sel,

    input  logic [15:0]     dp_a_data,
    input  logic            dp_zf_flag,

    output logic [PC_W-1:0] cu_pc,
    output logic            cu_halted
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StRead,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_t;

    localparam logic [3:0] OpLdi  = 4'h8;
    localparam logic [3:0] OpLd   = 4'h9;
    localparam logic [3:0] OpSt   = 4'hA;
    localparam logic [3:0] OpJmp  = 4'hB;
    localparam logic [3:0] OpJz   = 4'hC;
    localparam logic [3:0] OpHalt = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     mem_data_q, mem_data_d;
    logic [15:0]     wdata_q, wdata_d;

    logic            req_c, we_c, write_c, a_read_c, b_read_c;
    logic [PC_W-1:0] addr_c;
    logic [1:0]      sel_c;

    logic [3:0]      op;
    logic [3:0]      rd;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [7:0]      imm;
    logic            is_alu;
    logic [PC_W-1:0] imm_pc;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ra     = ir_q[7:4];
    assign rb     = ir_q[3:0];
    assign imm    = ir_q[7:0];
    assign is_alu = ~op[3];
    assign imm_pc = PC_W'(imm);

    // State, PC, IR and latched data registers with synchronous active-low reset.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            mem_data_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_data_q <= mem_data_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_data_d = mem_data_q;
        wdata_d    = wdata_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        write_c    = 1'b0;
        a_read_c   = 1'b0;
        b_read_c   = 1'b0;
        sel_c      = 2'd0;

        unique case (state_q)
            StFetch: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_alu || op == OpSt || op == OpJz) begin
                    state_d = StRead;
                end else if (op == OpLdi) begin
                    state_d = StWb;
                end else if (op == OpLd) begin
                    state_d = StMem;
                end else if (op == OpJmp) begin
                    pc_d    = imm_pc;
                    state_d = StFetch;
                end else if (op == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StRead: begin
                a_read_c = 1'b1;
                b_read_c = is_alu;
                if (op == OpSt) begin
                    // Store data is held here so mem_wdata stays stable while waiting for ack.
                    wdata_d = dp_a_data;
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                write_c = is_alu;
                if (op == OpJz && dp_zf_flag) begin
                    pc_d = imm_pc;
                end
                state_d = StFetch;
            end
            StMem: begin
                req_c  = 1'b1;
                addr_c = imm_pc;
                we_c   = (op == OpSt);
                if (mem_ack) begin
                    if (op == OpSt) begin
                        state_d = StFetch;
                    end else begin
                        mem_data_d = mem_rdata;
                        state_d    = StWb;
                    end
                end
            end
            StWb: begin
                write_c = 1'b1;
                sel_c   = (op == OpLd) ? 2'd1 : 2'd2;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Requests and strobes are suppressed while reset is held.
    assign mem_req   = req_c & CPU_RESETN;
    assign mem_we    = we_c & CPU_RESETN;
    assign cu_write  = write_c & CPU_RESETN;
    assign cu_a_read = a_read_c & CPU_RESETN;
    assign cu_b_read = b_read_c & CPU_RESETN;

    assign mem_addr      = addr_c;
    assign mem_wdata     = wdata_q;
    assign cu_mem_data   = mem_data_q;
    assign cu_imm        = imm;
    assign cu_sel        = sel_c;
    assign cu_write_addr = rd;
    assign cu_a_addr     = (op == OpSt || op == OpJz) ? rd : ra;
    assign cu_b_addr     = rb;
    assign cu_alu_sel    = {1'b0, op[2:0]};
    assign cu_pc         = pc_q;
    assign cu_halted     = (state_q == StHalt);

endmodule
